// File: rtl/conv_pad_stream_if.sv
// Stream bundle around the padding stage: unpadded pixels in, padded pixels plus frame markers out.
// master is the padding stage itself; slave is the surrounding source/sink.
interface conv_pad_stream_if #(
    parameter int BW = 32
);
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eol, out_eof
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/conv_pad_stream.sv
// Streaming zero-padding stage: wraps an IMG_W x IMG_H raster in a PAD-pixel border, no frame memory.
// Define PAD_CONST_EN to add the pad_value port; otherwise border pixels are all-zero.
module conv_pad_stream #(
    parameter int IMG_W      = 35,
    parameter int IMG_H      = 35,
    parameter int PAD        = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
`ifdef PAD_CONST_EN
    input  logic [DATA_WIDTH*CHANNELS-1:0] pad_value,
`endif
    output logic busy,
    conv_pad_stream_if.master st
);
    // state | meaning
    // IDLE  | no frame in progress; waits for en
    // RUN   | walking the padded raster; en is only looked at on the last pixel load

    localparam int BW = DATA_WIDTH * CHANNELS;
    localparam int OW = IMG_W + 2 * PAD;
    localparam int OH = IMG_H + 2 * PAD;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW = (OH > 1) ? $clog2(OH) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(OW - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(OH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] data_q;
    logic          valid_q, sof_q, eol_q, eof_q;
    logic          interior, col_last, row_last;
    logic          load_en, load, in_ready_c;
    logic [BW-1:0] fill_value, load_data;

`ifdef PAD_CONST_EN
    assign fill_value = pad_value;
`else
    assign fill_value = '0;
`endif

    // Border bands only exist when PAD > 0; the whole raster is interior otherwise.
    if (PAD == 0) begin : g_no_pad
        assign interior = 1'b1;
    end else begin : g_pad
        localparam logic [CW-1:0] COL_LO = CW'(PAD);
        localparam logic [CW-1:0] COL_HI = CW'(PAD + IMG_W - 1);
        localparam logic [RW-1:0] ROW_LO = RW'(PAD);
        localparam logic [RW-1:0] ROW_HI = RW'(PAD + IMG_H - 1);
        assign interior = (col_q >= COL_LO) && (col_q <= COL_HI) &&
                          (row_q >= ROW_LO) && (row_q <= ROW_HI);
    end

    assign col_last  = (col_q == COL_MAX);
    assign row_last  = (row_q == ROW_MAX);
    assign load_en   = (state_q == RUN) && (!valid_q || st.out_ready);
    assign load_data = interior ? st.in_data : fill_value;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        load       = 1'b0;
        in_ready_c = 1'b0;

        if (load_en) begin
            if (interior) begin
                in_ready_c = 1'b1;
                load       = st.in_valid;
            end else begin
                load = 1'b1;
            end
        end

        if (load) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (load && col_last && row_last && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Markers ride in the same register as the pixel they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
            sof_q   <= (col_q == '0) && (row_q == '0);
            eol_q   <= col_last;
            eof_q   <= col_last && row_last;
        end else if (valid_q && st.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign st.in_ready  = in_ready_c;
    assign st.out_data  = data_q;
    assign st.out_valid = valid_q;
    assign st.out_sof   = sof_q;
    assign st.out_eol   = eol_q;
    assign st.out_eof   = eof_q;
    assign busy         = (state_q == RUN);
endmodule

// File: tb/tb_conv_pad_stream.sv
// Bench for conv_pad_stream: 3x2 frame with PAD=1 (dut_a) and 4x1 pass-through with PAD=0 (dut_b).
// Expected streams come from a raster model of the padded frame; literal tables pin that model.
module tb_conv_pad_stream;
    localparam int DW = 8;
`ifdef PAD_CONST_EN
    localparam logic [DW-1:0] FILL = 8'hFF;
`else
    localparam logic [DW-1:0] FILL = 8'h00;
`endif
    typedef logic [DW+2:0] ent_t;   // {data, sof, eol, eof}

    logic clk = 1'b0;
    logic reset;
    logic en_a, en_b, busy_a, busy_b;
`ifdef PAD_CONST_EN
    logic [DW-1:0] pad_value;
`endif

    conv_pad_stream_if #(.BW(DW)) ifa ();
    conv_pad_stream_if #(.BW(DW)) ifb ();

    conv_pad_stream #(.IMG_W(3), .IMG_H(2), .PAD(1), .DATA_WIDTH(DW), .CHANNELS(1)) dut_a (
        .clk(clk), .reset(reset), .en(en_a),
`ifdef PAD_CONST_EN
        .pad_value(pad_value),
`endif
        .busy(busy_a), .st(ifa)
    );

    conv_pad_stream #(.IMG_W(4), .IMG_H(1), .PAD(0), .DATA_WIDTH(DW), .CHANNELS(1)) dut_b (
        .clk(clk), .reset(reset), .en(en_b),
`ifdef PAD_CONST_EN
        .pad_value(pad_value),
`endif
        .busy(busy_b), .st(ifb)
    );

    always #5 clk = ~clk;

    int checks, errors, cyc, tog;
    bit gate_a, toggle_a;
    ent_t exp_a[$], exp_b[$], log_a[$], log_b[$];
    logic [DW-1:0] in_a[$], in_b[$];
    int cyc_a[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Raster model: walk the padded frame, interior positions consume the next input pixel.
    task automatic push_frame(input bit sel, input int w, input int h, input int p, input int first);
        int ow = w + 2 * p;
        int oh = h + 2 * p;
        int k = first;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                logic [DW-1:0] d;
                ent_t e;
                bit inner;
                inner = (r >= p) && (r < p + h) && (c >= p) && (c < p + w);
                d = inner ? DW'(k) : FILL;
                if (inner) begin
                    k++;
                    if (sel) in_b.push_back(d); else in_a.push_back(d);
                end
                e = {d, (r == 0 && c == 0), (c == ow - 1), (c == ow - 1 && r == oh - 1)};
                if (sel) exp_b.push_back(e); else exp_a.push_back(e);
            end
        end
    endtask

    // Compare process: any visible output must equal the head of the model stream.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (ifa.out_valid) begin
                if (exp_a.size() == 0) begin
                    fail("a_extra_output", 1, 0);
                end else begin
                    chk("a_out", int'({ifa.out_data, ifa.out_sof, ifa.out_eol, ifa.out_eof}), int'(exp_a[0]));
                    if (ifa.out_ready) void'(exp_a.pop_front());
                end
                if (ifa.out_ready) begin
                    log_a.push_back({ifa.out_data, ifa.out_sof, ifa.out_eol, ifa.out_eof});
                    cyc_a.push_back(cyc);
                end
            end
            if (ifb.out_valid) begin
                if (exp_b.size() == 0) begin
                    fail("b_extra_output", 1, 0);
                end else begin
                    chk("b_out", int'({ifb.out_data, ifb.out_sof, ifb.out_eol, ifb.out_eof}), int'(exp_b[0]));
                    if (ifb.out_ready) void'(exp_b.pop_front());
                end
                if (ifb.out_ready) log_b.push_back({ifb.out_data, ifb.out_sof, ifb.out_eol, ifb.out_eof});
            end
            if (ifa.in_valid && ifa.in_ready && in_a.size() != 0) void'(in_a.pop_front());
            if (ifb.in_valid && ifb.in_ready && in_b.size() != 0) void'(in_b.pop_front());
        end
    end

    // Source/sink driver, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        tog++;
        ifa.in_valid  = gate_a && (in_a.size() != 0);
        ifa.in_data   = (in_a.size() != 0) ? in_a[0] : '0;
        ifa.out_ready = toggle_a ? tog[0] : 1'b1;
        ifb.in_valid  = (in_b.size() != 0);
        ifb.in_data   = (in_b.size() != 0) ? in_b[0] : '0;
        ifb.out_ready = 1'b1;
    end

    task automatic start_a();
        @(negedge clk); en_a = 1'b1;
        @(negedge clk); en_a = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (k >= maxc) fail("drain_timeout", k, maxc);
    endtask

    task automatic wait_log_a(input int n, input int maxc);
        int k = 0;
        while (log_a.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (k >= maxc) fail("wait_log_timeout", log_a.size(), n);
    endtask

    task automatic check_lit_a(input string tag);
        logic [DW-1:0] lit [20];
        lit = '{FILL, FILL, FILL, FILL, FILL, FILL, 8'd1, 8'd2, 8'd3, FILL,
                FILL, 8'd4, 8'd5, 8'd6, FILL, FILL, FILL, FILL, FILL, FILL};
        for (int i = 0; i < 20; i++) begin
            if (i >= log_a.size()) begin
                fail({tag, "_missing"}, i, 20);
                break;
            end
            chk({tag, "_data"}, int'(log_a[i][DW+2:3]), int'(lit[i]));
            chk({tag, "_sof"}, int'(log_a[i][2]), int'(i == 0));
            chk({tag, "_eol"}, int'(log_a[i][1]), int'(i == 4 || i == 9 || i == 14 || i == 19));
            chk({tag, "_eof"}, int'(log_a[i][0]), int'(i == 19));
        end
    endtask

    initial begin
        int k;
        logic [DW-1:0] lit_b [4];
        checks = 0; errors = 0; cyc = 0; tog = 0;
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; gate_a = 1'b1; toggle_a = 1'b0;
`ifdef PAD_CONST_EN
        pad_value = 8'hFF;
`endif
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", int'(ifa.out_valid), 0);
        chk("rst_data", int'(ifa.out_data), 0);
        chk("rst_sof", int'(ifa.out_sof), 0);
        chk("rst_eol", int'(ifa.out_eol), 0);
        chk("rst_eof", int'(ifa.out_eof), 0);
        chk("rst_in_ready", int'(ifa.in_ready), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_b_valid", int'(ifb.out_valid), 0);
        reset = 1'b0;

        // Single frame, always ready: start-up timing, full sequence, no bubbles
        push_frame(0, 3, 2, 1, 1);
        @(negedge clk); en_a = 1'b1;
        @(negedge clk);
        chk("t1_busy_edge0", int'(busy_a), 1);
        chk("t1_valid_edge0", int'(ifa.out_valid), 0);
        en_a = 1'b0;
        @(negedge clk);
        chk("t1_valid_edge1", int'(ifa.out_valid), 1);
        chk("t1_sof_edge1", int'(ifa.out_sof), 1);
        chk("t1_data_edge1", int'(ifa.out_data), int'(FILL));
        drain(200);
        chk("t1_count", log_a.size(), 20);
        check_lit_a("t1");
        if (log_a.size() == 20) chk("t1_span", cyc_a[19] - cyc_a[0], 19);

        // out_ready toggling: stalls must hold data and markers
        log_a.delete(); cyc_a.delete();
        toggle_a = 1'b1;
        push_frame(0, 3, 2, 1, 1);
        start_a();
        drain(400);
        chk("t2_count", log_a.size(), 20);
        check_lit_a("t2");
        toggle_a = 1'b0;

        // in_valid low for 3 cycles at the first interior position
        log_a.delete(); cyc_a.delete();
        gate_a = 1'b0;
        push_frame(0, 3, 2, 1, 1);
        start_a();
        k = 0;
        while (!ifa.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t3_first_ready", int'(ifa.in_ready), 1);
        chk("t3_border_visible", int'(ifa.out_valid), 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_ready_hold", int'(ifa.in_ready), 1);
            chk("t3_valid_drop", int'(ifa.out_valid), 0);
        end
        gate_a = 1'b1;
        @(negedge clk);
        chk("t3_ready_at_rise", int'(ifa.in_ready), 1);
        chk("t3_in_valid_rise", int'(ifa.in_valid), 1);
        @(negedge clk);
        chk("t3_px1_valid", int'(ifa.out_valid), 1);
        chk("t3_px1_data", int'(ifa.out_data), 1);
        drain(200);
        chk("t3_count", log_a.size(), 20);
        check_lit_a("t3");

        // Back-to-back frames, en dropped mid-frame 2
        log_a.delete(); cyc_a.delete();
        push_frame(0, 3, 2, 1, 7);
        push_frame(0, 3, 2, 1, 13);
        @(negedge clk); en_a = 1'b1;
        wait_log_a(25, 200);
        en_a = 1'b0;
        k = 0;
        while (!(ifa.out_valid && ifa.out_eof) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_eof_seen", int'(ifa.out_valid && ifa.out_eof), 1);
        chk("t4_busy_after_eof", int'(busy_a), 0);
        drain(200);
        chk("t4_count", log_a.size(), 40);
        if (log_a.size() == 40) begin
            chk("t4_eof1", int'(log_a[19][0]), 1);
            chk("t4_sof2", int'(log_a[20][2]), 1);
            chk("t4_gap", cyc_a[20] - cyc_a[19], 1);
            chk("t4_f2_first_px", int'(log_a[26][DW+2:3]), 13);
            chk("t4_eof2", int'(log_a[39][0]), 1);
        end else begin
            fail("t4_log_size", log_a.size(), 40);
        end

        // Reset mid-frame at output 7, then restart
        log_a.delete(); cyc_a.delete();
        push_frame(0, 3, 2, 1, 1);
        start_a();
        wait_log_a(7, 100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_a.delete(); in_a.delete();
        #1;
        chk("t5_valid", int'(ifa.out_valid), 0);
        chk("t5_data", int'(ifa.out_data), 0);
        chk("t5_sof", int'(ifa.out_sof), 0);
        chk("t5_eol", int'(ifa.out_eol), 0);
        chk("t5_eof", int'(ifa.out_eof), 0);
        chk("t5_busy", int'(busy_a), 0);
        chk("t5_in_ready", int'(ifa.in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        log_a.delete(); cyc_a.delete();
        push_frame(0, 3, 2, 1, 'h21);
        start_a();
        drain(200);
        chk("t5_count", log_a.size(), 20);
        if (log_a.size() == 20) begin
            chk("t5_sof_first", int'(log_a[0][2]), 1);
            for (int i = 0; i < 6; i++) chk("t5_pad", int'(log_a[i][DW+2:3]), int'(FILL));
            chk("t5_first_px", int'(log_a[6][DW+2:3]), 'h21);
        end else begin
            fail("t5_log_size", log_a.size(), 20);
        end

        // PAD=0 pass-through
        lit_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        push_frame(1, 4, 1, 0, 'hA1);
        @(negedge clk); en_b = 1'b1;
        @(negedge clk);
        chk("t6_busy_edge0", int'(busy_b), 1);
        chk("t6_valid_edge0", int'(ifb.out_valid), 0);
        en_b = 1'b0;
        @(negedge clk);
        chk("t6_valid_edge1", int'(ifb.out_valid), 1);
        chk("t6_sof_edge1", int'(ifb.out_sof), 1);
        chk("t6_data_edge1", int'(ifb.out_data), 'hA1);
        drain(100);
        chk("t6_count", log_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i >= log_b.size()) begin
                fail("t6_missing", i, 4);
                break;
            end
            chk("t6_data", int'(log_b[i][DW+2:3]), int'(lit_b[i]));
            chk("t6_sof", int'(log_b[i][2]), int'(i == 0));
            chk("t6_eol", int'(log_b[i][1]), int'(i == 3));
            chk("t6_eof", int'(log_b[i][0]), int'(i == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end
endmodule
